riscv_muldiv_unit: RTL and testbench

- Iterative RV32M/RV64M multiply/divide unit that replaces the single-cycle combinational mul/div operators in the datapath.
- Accepts one operation through a valid/ready request port. Computes it over XLEN/BITS_PER_CYCLE cycles and returns the result through a valid/ready response port.
- The datapath stalls its PC on busy and writes the returned result into rd, identified by the tag.

---
 rtl/riscv_m_pkg.sv | 28 ++
 rtl/riscv_muldiv_step.sv | 39 +++
 rtl/riscv_muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_m_pkg.sv
// Shared encodings for the iterative RV32M/RV64M multiply/divide unit:
// funct3 op codes, FSM states and a two's-complement magnitude helper.
package riscv_m_pkg;

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  localparam int MAX_XLEN = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Callers zero-extend into MAX_XLEN and truncate the result back to XLEN.
  function automatic logic [MAX_XLEN-1:0] twos_mag(input logic [MAX_XLEN-1:0] v,
                                                   input logic                neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/riscv_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply (multiplier in lo, LSB first)
// or restoring subtract for divide (dividend in lo, MSB first; remainder in hi).
module riscv_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    rem_sh = {hi, lo[XLEN-1]};
    // rem_sh < 2*b, so one extra bit is enough for the borrow to show the sign
    diff   = rem_sh - {1'b0, b};
    if (is_div) begin
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative mul/div: XLEN/BITS_PER_CYCLE+1 cycles accept-to-response, 1 cycle for div-by-zero/overflow.
// Response is held in DONE until out_ready; a new request is accepted in the same cycle it is taken.
module riscv_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  import riscv_m_pkg::*;

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   acc_hi, acc_lo, opnd_b;
  logic [XLEN-1:0]   chain_hi, chain_lo;

  logic              accept, special;
  logic              rs1_signed, rs2_signed, a_neg, b_neg, neg_in;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, final_res;
  logic [2*XLEN-1:0] prod, prod_fin;

  assign accept = in_valid && in_ready;

  // Request decode: operand signedness, magnitudes and the early-out cases.
  always_comb begin
    rs1_signed  = (in_op == MULH) || (in_op == MULHSU) || (in_op == DIV) || (in_op == REM);
    rs2_signed  = (in_op == MULH) || (in_op == DIV) || (in_op == REM);
    a_neg       = rs1_signed && in_rs1[XLEN-1];
    b_neg       = rs2_signed && in_rs2[XLEN-1];
    neg_in      = (in_op == REM || in_op == REMU) ? a_neg : (a_neg ^ b_neg);
    a_mag       = XLEN'(twos_mag(MAX_XLEN'(in_rs1), a_neg));
    b_mag       = XLEN'(twos_mag(MAX_XLEN'(in_rs2), b_neg));
    div_zero    = in_op[2] && (in_rs2 == '0);
    div_ovf     = (in_op == DIV || in_op == REM) &&
                  (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&in_rs2);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)     special_res = in_op[1] ? in_rs1 : '1;
    else if (div_ovf) special_res = in_op[1] ? '0 : in_rs1;
  end

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_stage
    logic [XLEN-1:0] hi_i, lo_i, hi_o, lo_o;
    if (i == 0) begin : g_first
      assign hi_i = acc_hi;
      assign lo_i = acc_lo;
    end else begin : g_next
      assign hi_i = g_stage[i-1].hi_o;
      assign lo_i = g_stage[i-1].lo_o;
    end
    riscv_muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div (op_q[2]),
      .hi     (hi_i),
      .lo     (lo_i),
      .b      (opnd_b),
      .hi_nxt (hi_o),
      .lo_nxt (lo_o)
    );
  end

  assign chain_hi = g_stage[BITS_PER_CYCLE-1].hi_o;
  assign chain_lo = g_stage[BITS_PER_CYCLE-1].lo_o;

  // Sign fix-up on the last iteration's output; the product is negated at full width.
  always_comb begin
    prod      = {chain_hi, chain_lo};
    prod_fin  = neg_q ? -prod : prod;
    final_res = '0;
    case (op_q)
      MUL:                 final_res = prod_fin[XLEN-1:0];
      MULH, MULHSU, MULHU: final_res = prod_fin[2*XLEN-1:XLEN];
      DIV, DIVU:           final_res = neg_q ? -chain_lo : chain_lo;
      REM, REMU:           final_res = neg_q ? -chain_hi : chain_hi;
      default:             final_res = '0;
    endcase
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = special ? S_DONE : S_CALC;
      S_CALC: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = accept ? (special ? S_DONE : S_CALC) : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_comb begin
    in_ready  = !flush && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    out_valid = (state == S_DONE);
    busy      = (state == S_CALC) || (state == S_DONE);
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      cnt        <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opnd_b     <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (accept) begin
      cnt     <= CNT_W'(ITERS);
      op_q    <= in_op;
      neg_q   <= neg_in;
      acc_hi  <= '0;
      acc_lo  <= a_mag;
      opnd_b  <= b_mag;
      out_tag <= in_tag;
      if (special) out_result <= special_res;
    end else if (state == S_CALC && !flush) begin
      acc_hi <= chain_hi;
      acc_lo <= chain_lo;
      cnt    <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) out_result <= final_res;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit: XLEN=32 at 1 and 4 bits per cycle,
// hand-computed results, latencies, back-pressure, flush and reset kill paths.
module tb_riscv_muldiv_unit;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0, in_valid4 = 1'b0;
  logic        in_ready, in_ready4;
  logic [2:0]  in_op = 3'd0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid, out_valid4;
  logic        out_ready = 1'b1, out_ready4 = 1'b1;
  logic [31:0] out_result, out_result4;
  logic [4:0]  out_tag, out_tag4;
  logic        busy, busy4;

  int vectors = 0;
  int miscompares = 0;

  always #5 SYS_clk = ~SYS_clk;

  riscv_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  riscv_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) dut4 (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .flush(flush),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_result(out_result4),
    .out_tag(out_tag4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the BPC=1 unit, measure accept-to-valid latency, check and consume.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int exp_lat,
                        input string nm);
    int lat;
    in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag; in_valid = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge SYS_clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge SYS_clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_result"}, out_result, exp);
    chk({nm, "_tag"}, out_tag, tag);
    if (out_ready) begin
      @(posedge SYS_clk); #1;
      chk({nm, "_consumed"}, out_valid, 0);
    end
  endtask

  initial begin
    int lat;
    int seen;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    @(posedge SYS_clk); #1;
    SYS_reset = 1'b1;
    @(posedge SYS_clk); #1;

    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, "mul_7_m3");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 33, "mulhu");
    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33, "mulh");
    run_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd3,  32'hFFFFFFFF, 33, "mulhsu");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 33, "div_m7_2");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33, "rem_m7_2");
    run_op(3'd5, 32'hFFFFFFF9, 32'd2,        5'd8,  32'h7FFFFFFC, 33, "divu");
    run_op(3'd7, 32'd100,      32'd7,        5'd10, 32'd2,        33, "remu_100_7");
    run_op(3'd4, 32'd123,      32'd0,        5'd11, 32'hFFFFFFFF, 1,  "div_by_0");
    run_op(3'd7, 32'd123,      32'd0,        5'd12, 32'd123,      1,  "remu_by_0");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1,  "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1,  "rem_ovf");

    // Back-pressure: response held for 10 cycles, then taken alongside a new accept.
    out_ready = 1'b0;
    run_op(3'd0, 32'd6, 32'd7, 5'd3, 32'd42, 33, "bp_mul");
    for (int i = 0; i < 10; i++) begin
      @(posedge SYS_clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", out_result, 42);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    in_op = 3'd5; in_rs1 = 32'd100; in_rs2 = 32'd7; in_tag = 5'd9; in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("bp_b2b_in_ready", in_ready, 1);
    @(posedge SYS_clk); #1;
    in_valid = 1'b0;
    chk("bp_b2b_taken", out_valid, 0);
    chk("bp_b2b_busy", busy, 1);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge SYS_clk); #1;
      lat++;
    end
    chk("bp_b2b_latency", lat, 33);
    chk("bp_b2b_result", out_result, 14);
    chk("bp_b2b_tag", out_tag, 9);
    @(posedge SYS_clk); #1;

    // Flush in the 10th CALC cycle: unit idles and never responds.
    in_op = 3'd0; in_rs1 = 32'd5; in_rs2 = 32'd5; in_tag = 5'd2; in_valid = 1'b1;
    @(posedge SYS_clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge SYS_clk); #1;
    end
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge SYS_clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    seen = 0;
    repeat (40) begin
      @(posedge SYS_clk); #1;
      if (out_valid) seen = 1;
    end
    chk("flush_no_response", seen, 0);

    // Reset mid-CALC clears outputs immediately.
    in_op = 3'd0; in_rs1 = 32'd3; in_rs2 = 32'd3; in_tag = 5'd7; in_valid = 1'b1;
    @(posedge SYS_clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge SYS_clk); #1;
    end
    chk("pre_rst_busy", busy, 1);
    SYS_reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_result", out_result, 0);
    chk("mid_rst_out_tag", out_tag, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge SYS_clk); #1;
    SYS_reset = 1'b1;
    @(posedge SYS_clk); #1;

    // BITS_PER_CYCLE=4 instance: 7 x -3 in 9 cycles.
    in_op = 3'd0; in_rs1 = 32'd7; in_rs2 = 32'hFFFFFFFD; in_tag = 5'd5; in_valid4 = 1'b1;
    #1;
    chk("bpc4_in_ready", in_ready4, 1);
    @(posedge SYS_clk); #1;
    in_valid4 = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 200) begin
      @(posedge SYS_clk); #1;
      lat++;
    end
    chk("bpc4_latency", lat, 9);
    chk("bpc4_result", out_result4, 32'hFFFFFFEB);
    chk("bpc4_tag", out_tag4, 5);
    @(posedge SYS_clk); #1;
    chk("bpc4_consumed", out_valid4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
